// File: rtl/adder_sum4_sched_if.sv
// Request/result bundle for the shared four-operand sum scheduler.
// The master side is the set of requesters plus the result consumer;
// the slave side is the scheduler itself.
interface adder_sum4_sched_if #(
    parameter int NREQ = 4,
    parameter int W    = 8
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*W-1:0] req_c;
    logic [NREQ*W-1:0] req_d;
    logic              res_valid;
    logic              res_ready;
    logic [W+1:0]      res_sum;
    logic [IDW-1:0]    res_id;

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output req_c,
        output req_d,
        output res_ready,
        input  req_ready,
        input  res_valid,
        input  res_sum,
        input  res_id
    );

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  req_c,
        input  req_d,
        input  res_ready,
        output req_ready,
        output res_valid,
        output res_sum,
        output res_id
    );
endinterface

// File: rtl/adder_sum4_sched.sv
// Shared four-operand accumulate adder, time-multiplexed between NREQ
// requesters. A round-robin arbiter picks a requester in IDLE, the FSM
// adds b, c and d onto a over three ACC cycles through one (W+2)-bit
// adder, and the tagged result is held in DONE until the consumer takes it.
module adder_sum4_sched #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    adder_sum4_sched_if.slave   bus,
    output logic                busy,
    output logic [15:0]         done_cnt
);
    localparam int IDW = $clog2(NREQ);
    localparam int SW  = W + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [IDW-1:0]  rr_ptr_r;
    logic [1:0]      step_r;
    logic [SW-1:0]   acc_r;
    logic [W-1:0]    op_b_r;
    logic [W-1:0]    op_c_r;
    logic [W-1:0]    op_d_r;
    logic            res_valid_r;
    logic [SW-1:0]   res_sum_r;
    logic [IDW-1:0]  res_id_r;
    logic            busy_r;
    logic [15:0]     done_cnt_r;

    logic            grant_found_s;
    logic [IDW-1:0]  grant_idx_s;
    logic [NREQ-1:0] req_ready_s;
    logic [W-1:0]    a_arr_s [NREQ];
    logic [W-1:0]    b_arr_s [NREQ];
    logic [W-1:0]    c_arr_s [NREQ];
    logic [W-1:0]    d_arr_s [NREQ];
    logic [W-1:0]    sel_a_s;
    logic [W-1:0]    sel_b_s;
    logic [W-1:0]    sel_c_s;
    logic [W-1:0]    sel_d_s;
    logic [W-1:0]    addend_s;
    logic [SW-1:0]   sum_s;

    // Requester index base+off, wrapped into 0..NREQ-1.
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int raw;
        raw = int'(base) + off;
        if (raw >= NREQ) begin
            raw = raw - NREQ;
        end else begin
            raw = raw;
        end
        return IDW'(raw);
    endfunction

    // Split the flat operand buses into per-requester slices.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr_s[g] = bus.req_a[g*W +: W];
        assign b_arr_s[g] = bus.req_b[g*W +: W];
        assign c_arr_s[g] = bus.req_c[g*W +: W];
        assign d_arr_s[g] = bus.req_d[g*W +: W];
    end

    // Round-robin search: first pending requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found_s && bus.req_valid[wrap_idx(rr_ptr_r, k)]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = wrap_idx(rr_ptr_r, k);
            end else begin
                grant_found_s = grant_found_s;
                grant_idx_s   = grant_idx_s;
            end
        end
    end

    // Operands of the currently selected requester, sampled only on a grant.
    always_comb begin
        sel_a_s = a_arr_s[grant_idx_s];
        sel_b_s = b_arr_s[grant_idx_s];
        sel_c_s = c_arr_s[grant_idx_s];
        sel_d_s = d_arr_s[grant_idx_s];
    end

    // One-hot accept strobe, only in IDLE and never while reset is asserted.
    always_comb begin
        req_ready_s = '0;
        if (rst_n && (state_r == ST_IDLE) && grant_found_s) begin
            req_ready_s[grant_idx_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    // The single shared adder: step selects which latched operand is added.
    always_comb begin
        case (step_r)
            2'd0:    addend_s = op_b_r;
            2'd1:    addend_s = op_c_r;
            2'd2:    addend_s = op_d_r;
            default: addend_s = '0;
        endcase
        sum_s = acc_r + {2'b00, addend_s};
    end

    // Control FSM with its registered outputs: grant bookkeeping, step count, result port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= '0;
            step_r      <= 2'd0;
            res_valid_r <= 1'b0;
            res_sum_r   <= '0;
            res_id_r    <= '0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        res_id_r <= grant_idx_s;
                        rr_ptr_r <= wrap_idx(grant_idx_s, 1);
                        step_r   <= 2'd0;
                        busy_r   <= 1'b1;
                        state_r  <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (step_r == 2'd2) begin
                        res_sum_r   <= sum_s;
                        res_valid_r <= 1'b1;
                        step_r      <= 2'd0;
                        state_r     <= ST_DONE;
                    end else begin
                        step_r <= step_r + 2'd1;
                    end
                end
                ST_DONE: begin
                    // Result held stable until the consumer takes it.
                    if (res_valid_r && bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    res_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    step_r      <= 2'd0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Datapath: capture operands on a grant, then accumulate one addend per ACC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r  <= '0;
            op_b_r <= '0;
            op_c_r <= '0;
            op_d_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        acc_r  <= {2'b00, sel_a_s};
                        op_b_r <= sel_b_s;
                        op_c_r <= sel_c_s;
                        op_d_r <= sel_d_s;
                    end
                end
                ST_ACC: begin
                    acc_r <= sum_s;
                end
                ST_DONE: begin
                    acc_r <= acc_r;
                end
                default: begin
                    acc_r <= '0;
                end
            endcase
        end
    end

    // Completed-result counter, one increment per result handshake, wraps freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt_r <= 16'd0;
        end else if ((state_r == ST_DONE) && res_valid_r && bus.res_ready) begin
            done_cnt_r <= done_cnt_r + 16'd1;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.res_valid = res_valid_r;
    assign bus.res_sum   = res_sum_r;
    assign bus.res_id    = res_id_r;
    assign busy          = busy_r;
    assign done_cnt      = done_cnt_r;

endmodule

// File: tb/tb_adder_sum4_sched.sv
// Self-checking bench for adder_sum4_sched (NREQ=4, W=8): table of single
// requests plus hand-written latency, reset, round-robin, backpressure and
// counter-wrap sequences. Expected results go into a scoreboard queue on
// each grant and are compared when the result handshake happens.
module tb_adder_sum4_sched;
    localparam int NREQ = 4;
    localparam int W    = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic [15:0] done_cnt;

    adder_sum4_sched_if #(.NREQ(NREQ), .W(W)) bus ();

    adder_sum4_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .done_cnt (done_cnt)
    );

    always #5 clk = ~clk;

    logic [W-1:0] oa [NREQ];
    logic [W-1:0] ob [NREQ];
    logic [W-1:0] oc [NREQ];
    logic [W-1:0] od [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign bus.req_a[g*W +: W] = oa[g];
        assign bus.req_b[g*W +: W] = ob[g];
        assign bus.req_c[g*W +: W] = oc[g];
        assign bus.req_d[g*W +: W] = od[g];
    end

    typedef struct {
        int id;
        int sum;
    } exp_t;

    typedef struct {
        int id;
        int a;
        int b;
        int c;
        int d;
        int exp_sum;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    exp_t        sb [$];
    logic [15:0] exp_done;
    vec_t        vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic set_ops(input int i, input int a, input int b, input int c, input int d);
        oa[i] = W'(a);
        ob[i] = W'(b);
        oc[i] = W'(c);
        od[i] = W'(d);
    endtask

    function automatic int model_sum(input int i);
        return int'(oa[i]) + int'(ob[i]) + int'(oc[i]) + int'(od[i]);
    endfunction

    function automatic logic [31:0] onehot(input int i);
        return 32'd1 << i;
    endfunction

    // Drive req_valid=mask from a negedge and expect n grants in order ids[];
    // each grant pushes its expected result. Returns at a negedge with req_valid low.
    task automatic run_grants(input logic [NREQ-1:0] mask, input int ids[8], input int sums[8],
                              input int n, input bit check_gap);
        int  k;
        int  cyc;
        time last_t;
        exp_t e;
        k      = 0;
        cyc    = 0;
        last_t = 0;
        bus.req_valid = mask;
        while (k < n && cyc < 10 * n + 10) begin
            #1;
            if (bus.req_ready != '0) begin
                check("grant_onehot", 32'(bus.req_ready), onehot(ids[k]));
                if (check_gap && k > 0) begin
                    check("grant_gap", 32'($time - last_t), 32'd50);
                end
                last_t = $time;
                e.id   = ids[k];
                e.sum  = sums[k];
                sb.push_back(e);
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.req_valid = '0;
        check("grant_count", 32'(k), 32'(n));
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while ((sb.size() != 0 || busy) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("drain_done", 32'(sb.size() == 0 && !busy), 32'd1);
    endtask

    // Scoreboard pop: the handshake that will occur at the coming rising edge.
    always begin : monitor
        exp_t e;
        @(negedge clk);
        #3;
        if (rst_n === 1'b1 && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual_id=%0d actual_sum=%0d expected=none",
                         bus.res_id, bus.res_sum);
            end else begin
                e = sb.pop_front();
                check("res_sum", 32'(bus.res_sum), 32'(e.sum));
                check("res_id", 32'(bus.res_id), 32'(e.id));
            end
            exp_done = exp_done + 16'd1;
        end
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{id: 0, a: 0,   b: 0,   c: 0,   d: 0,   exp_sum: 0};
        vecs[1] = '{id: 1, a: 255, b: 0,   c: 0,   d: 0,   exp_sum: 255};
        vecs[2] = '{id: 2, a: 255, b: 255, c: 255, d: 255, exp_sum: 1020};
        vecs[3] = '{id: 3, a: 128, b: 128, c: 128, d: 128, exp_sum: 512};
        vecs[4] = '{id: 1, a: 1,   b: 254, c: 3,   d: 252, exp_sum: 510};
        vecs[5] = '{id: 2, a: 17,  b: 34,  c: 51,  d: 68,  exp_sum: 170};

        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        exp_done      = 16'd0;
        for (int i = 0; i < NREQ; i++) set_ops(i, 0, 0, 0, 0);

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_done_cnt", 32'(done_cnt), 32'd0);
        check("rst_res_sum", 32'(bus.res_sum), 32'd0);
        check("rst_res_id", 32'(bus.res_id), 32'd0);

        // Single request: 1+2+3+4, exact 3-cycle latency.
        @(negedge clk);
        set_ops(0, 1, 2, 3, 4);
        bus.req_valid = 4'b0001;
        #1;
        check("t2_req_ready", 32'(bus.req_ready), 32'd1);
        sb.push_back('{id: 0, sum: 10});
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        #1;
        for (int c = 0; c < 3; c++) begin
            check("t2_lat_valid_low", 32'(bus.res_valid), 32'd0);
            check("t2_busy_high", 32'(busy), 32'd1);
            @(negedge clk);
            #1;
        end
        check("t2_valid_at_3", 32'(bus.res_valid), 32'd1);
        check("t2_sum", 32'(bus.res_sum), 32'd10);
        check("t2_id", 32'(bus.res_id), 32'd0);
        @(negedge clk);
        #1;
        check("t2_busy_drop", 32'(busy), 32'd0);
        check("t2_valid_drop", 32'(bus.res_valid), 32'd0);
        check("t2_done_cnt", 32'(done_cnt), 32'd1);

        // Table of single-requester vectors.
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            set_ops(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].d);
            run_grants(NREQ'(onehot(vecs[v].id)), '{vecs[v].id, 0, 0, 0, 0, 0, 0, 0},
                       '{vecs[v].exp_sum, 0, 0, 0, 0, 0, 0, 0}, 1, 1'b0);
            drain();
            check("tbl_done_cnt", 32'(done_cnt), 32'(exp_done));
        end

        // Reset in the middle of an accumulation.
        @(negedge clk);
        set_ops(3, 7, 7, 7, 7);
        bus.req_valid = 4'b1000;
        #1;
        check("rstmid_grant", 32'(bus.req_ready), 32'd8);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid_res_valid", 32'(bus.res_valid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_req_ready", 32'(bus.req_ready), 32'd0);
        exp_done = 16'd0;
        @(negedge clk);
        bus.req_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rstmid_done_cnt", 32'(done_cnt), 32'd0);
        check("rstmid_no_result", 32'(bus.res_valid), 32'd0);

        // Round-robin with all four requesting: 0,1,2,3,0 five cycles apart.
        set_ops(0, 1, 2, 3, 4);
        set_ops(1, 10, 20, 30, 40);
        set_ops(2, 100, 50, 25, 5);
        set_ops(3, 200, 201, 202, 203);
        @(negedge clk);
        run_grants(4'b1111, '{0, 1, 2, 3, 0, 0, 0, 0},
                   '{model_sum(0), model_sum(1), model_sum(2), model_sum(3), model_sum(0), 0, 0, 0},
                   5, 1'b1);
        drain();

        // Move rr_ptr to 2, then 1010 alternates 3,1,3,1.
        @(negedge clk);
        run_grants(4'b0010, '{1, 0, 0, 0, 0, 0, 0, 0}, '{model_sum(1), 0, 0, 0, 0, 0, 0, 0}, 1, 1'b0);
        drain();
        @(negedge clk);
        run_grants(4'b1010, '{3, 1, 3, 1, 0, 0, 0, 0},
                   '{model_sum(3), model_sum(1), model_sum(3), model_sum(1), 0, 0, 0, 0}, 4, 1'b1);
        drain();

        // Backpressure with maximum operands on requester 2 (rr_ptr is 2 here).
        set_ops(2, 255, 255, 255, 255);
        bus.res_ready = 1'b0;
        @(negedge clk);
        run_grants(4'b1111, '{2, 0, 0, 0, 0, 0, 0, 0}, '{1020, 0, 0, 0, 0, 0, 0, 0}, 1, 1'b0);
        bus.req_valid = 4'b1111;
        begin
            int cyc;
            cyc = 0;
            #1;
            while (bus.res_valid !== 1'b1 && cyc < 10) begin
                @(negedge clk);
                #1;
                cyc++;
            end
        end
        for (int c = 0; c < 6; c++) begin
            check("bp_valid", 32'(bus.res_valid), 32'd1);
            check("bp_sum", 32'(bus.res_sum), 32'h3FC);
            check("bp_id", 32'(bus.res_id), 32'd2);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
            check("bp_done_cnt", 32'(done_cnt), 32'(exp_done));
            @(negedge clk);
            #1;
        end
        bus.res_ready = 1'b1;
        check("bp_no_grant_in_done", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        run_grants(4'b1111, '{3, 0, 0, 0, 0, 0, 0, 0}, '{model_sum(3), 0, 0, 0, 0, 0, 0, 0}, 1, 1'b0);
        drain();
        check("bp_done_after", 32'(done_cnt), 32'(exp_done));

        // Counter wrap from 0xFFFF.
        @(negedge clk);
        force dut.done_cnt_r = 16'hFFFF;
        exp_done = 16'hFFFF;
        @(negedge clk);
        release dut.done_cnt_r;
        #1;
        check("wrap_preload", 32'(done_cnt), 32'hFFFF);
        @(negedge clk);
        set_ops(0, 9, 9, 9, 9);
        run_grants(4'b0001, '{0, 0, 0, 0, 0, 0, 0, 0}, '{36, 0, 0, 0, 0, 0, 0, 0}, 1, 1'b0);
        drain();
        #1;
        check("wrap_zero", 32'(done_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adder_sum4_sched.md
Name: adder_sum4_sched

Overview:
Time-multiplexes one shared 10-bit accumulate adder between NREQ requesters. Each requester submits four unsigned W-bit operands and receives their sum. A round-robin arbiter selects the requester, a small FSM sequences the adds over several cycles, and the result is returned through a valid/ready port tagged with the requester id. Sits in front of the datapath sum blocks, so several clients share one adder instead of each instantiating a 4-input adder tree.

Parameters:
NREQ, 4, number of requesters (2..8); IDW = clog2(NREQ), derived, not overridable.
W, 8, operand width; result width is W+2.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  NREQ  bit i: requester i has operands pending.
req_ready  out  NREQ  bit i: requester i's operands are accepted this cycle (one-hot or zero).
req_a, req_b, req_c, req_d  in  NREQ*W each  operand slice i at bits [i*W +: W].
res_valid  out  1  result available.
res_ready  in  1  consumer accepts the result.
res_sum  out  W+2  a+b+c+d of the granted request.
res_id  out  IDW  index of the requester the result belongs to.
busy  out  1  high whenever state != IDLE.
done_cnt  out  16  completed-result counter, wraps at 0xFFFF->0.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, rr_ptr=0, acc=0, step=0, res_valid=0, res_sum=0, res_id=0, req_ready=0, busy=0, done_cnt=0. Reset mid-operation discards the in-flight request with no result and no req_ready re-pulse.
- FSM states: IDLE, ACC, DONE.
- IDLE: if any req_valid, grant g = first set bit at or after rr_ptr, searching upward and wrapping. req_ready[g]=1 combinationally in the same cycle (depends only on state, rr_ptr and req_valid). At that edge: acc <= zero-extended a_g; latch b_g, c_g, d_g; res_id <= g; rr_ptr <= (g+1) mod NREQ; step <= 0; go to ACC. No req_valid: stay in IDLE, all outputs held.
- ACC: one add per cycle through a single (W+2)-bit adder. step 0 adds b, step 1 adds c, step 2 adds d. At the step-2 edge: res_sum <= final acc, res_valid <= 1, go to DONE.
- Latency: res_valid is high exactly 3 cycles after the acceptance edge.
- DONE: res_valid=1; res_sum and res_id held stable until res_valid & res_ready. At the handshake edge: res_valid <= 0, done_cnt += 1, go to IDLE.
- Throughput: at most one request per 5 cycles (IDLE 1 + ACC 3 + DONE 1 minimum). A new request is never accepted in the same cycle a result completes.
- req_ready is 0 in ACC and DONE. Requesters must hold req_valid and operands until their ready bit pulses; operands are sampled only at the grant edge.
- Arithmetic: unsigned, and it cannot overflow, since 4*(2^W-1) < 2^(W+2). Maximum for W=8 is 1020 (0x3FC).
- Fairness: a requester holding req_valid is served within NREQ grants.
- req_valid from a requester not granted is ignored and never dropped. Deasserting req_valid before grant is legal: the request is withdrawn.
- busy = (state != IDLE).

Test Plan:
1. Reset check: assert rst_n=0 mid-ACC after an accept -> immediately res_valid=0, busy=0, req_ready=0. After release, done_cnt=0 and the first grant goes to the lowest requester.
2. Single request: req_valid=0001, a=1, b=2, c=3, d=4, res_ready=1 -> req_ready=0001 for 1 cycle. res_valid high 3 cycles later with res_sum=10, res_id=0, then done_cnt=1 and busy drops the cycle after the handshake.
3. Max operands: requester 2 sends 255 on all four operands -> res_sum=1020 (0x3FC), res_id=2, no truncation.
4. Round-robin: req_valid=1111 held, res_ready=1 -> grant order 0,1,2,3,0 with results 5 cycles apart. Then hold only req_valid=1010 -> grants alternate 3,1,3,1 when rr_ptr starts at 2.
5. Backpressure: res_ready=0 for 6 cycles in DONE while req_valid=1111 -> res_valid, res_sum and res_id stable, req_ready=0000, done_cnt unchanged. Then res_ready=1 -> one handshake, then the next grant in IDLE.
6. Counter wrap: force 65536 completions (or preload done_cnt=0xFFFF via a bench force) -> done_cnt reads 0x0000 after the next completion.
